ftdi_rw_ctrl: RTL and testbench

FTDI_RW_CTRL -- requirements
Module: ftdi_rw_ctrl

---
 rtl/ftdi_pkg.sv | 29 ++
 rtl/ftdi_tcnt.sv | 39 +++
 rtl/ftdi_rw_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_ftdi_rw_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ftdi_pkg.sv
// ftdi_pkg: shared types and constants for the FTDI FIFO read/write controller.
//   state_e   - controller FSM states
//   CYC_MIN/CYC_MAX - legal range of the strobe/recovery cycle parameters
//   TCNT_W    - width of the phase timer
//   cyc_load  - converts a phase length in cycles into a timer load value
package ftdi_pkg;

  localparam int unsigned CYC_MIN = 1;
  localparam int unsigned CYC_MAX = 15;
  localparam int unsigned TCNT_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_TURN  = 3'd1,
    ST_RD_STRB  = 3'd2,
    ST_WR_SETUP = 3'd3,
    ST_WR_STRB  = 3'd4,
    ST_RECOVER  = 3'd5
  } state_e;

  // The timer reaches zero on the last cycle of a phase, so an N-cycle
  // phase loads N-1. Out-of-range lengths are clamped.
  function automatic logic [TCNT_W-1:0] cyc_load(input int unsigned cyc);
    int unsigned c;
    c = (cyc < CYC_MIN) ? CYC_MIN : ((cyc > CYC_MAX) ? CYC_MAX : cyc);
    return TCNT_W'(c - 1);
  endfunction

endpackage

// File: rtl/ftdi_tcnt.sv
// ftdi_tcnt: loadable down-counter timing the strobe and recovery phases.
//   clk, n_rst  - clock, synchronous active-low reset (count -> 0)
//   load_i      - load load_val_i (has priority over dec_i)
//   load_val_i  - value to load
//   dec_i       - decrement by one, saturating at zero
//   zero_o      - count is zero
module ftdi_tcnt
  import ftdi_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              load_i,
  input  logic [TCNT_W-1:0] load_val_i,
  input  logic              dec_i,
  output logic              zero_o
);

  logic [TCNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - TCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ftdi_rw_ctrl.sv
// ftdi_rw_ctrl: FTDI async FIFO (245-style) read/write strobe controller.
//   clk, n_rst          - clock, synchronous active-low reset
//   rxf, txe            - FTDI rx-data-available / tx-space-available (active-low)
//   rd, wr              - FTDI read / write strobes (active-low)
//   oe                  - 1 when this block drives dq
//   dq                  - bidirectional FIFO data bus
//   tx_data/valid/ready - user write stream (word latched on handshake)
//   rx_data/valid/ready - user read stream (held until accepted)
module ftdi_rw_ctrl
  import ftdi_pkg::*;
#(
  parameter int unsigned DW      = 8,
  parameter int unsigned RD_CYC  = 2,
  parameter int unsigned WR_CYC  = 2,
  parameter int unsigned REC_CYC = 1,
  parameter int unsigned ARB_RR  = 0
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          rxf,
  input  logic          txe,
  output logic          rd,
  output logic          wr,
  output logic          oe,
  inout  wire  [DW-1:0] dq,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  input  logic          rx_ready
);

  state_e            state_q, state_d;
  logic [DW-1:0]     wdata_q;
  logic [DW-1:0]     rx_data_q;
  logic              rx_valid_q;
  logic              prefer_tx_q;
  logic              oe_hold_q;

  logic              rx_pend, tx_pend;
  logic              grant_rx, grant_tx;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic [TCNT_W-1:0] cnt_val;
  logic              rd_done, wr_done;

  ftdi_tcnt u_tcnt (
    .clk        (clk),
    .n_rst      (n_rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // A read is only worth starting if the user side can take the word.
  assign rx_pend = !rxf && rx_ready && !rx_valid_q;
  assign tx_pend = !txe && tx_valid;

  always_comb begin
    grant_rx = 1'b0;
    grant_tx = 1'b0;
    if (rx_pend && tx_pend) begin
      if ((ARB_RR != 0) && prefer_tx_q) begin
        grant_tx = 1'b1;
      end else begin
        grant_rx = 1'b1;
      end
    end else begin
      grant_rx = rx_pend;
      grant_tx = tx_pend;
    end
  end

  assign rd_done = (state_q == ST_RD_STRB) && cnt_zero;
  assign wr_done = (state_q == ST_WR_STRB) && cnt_zero;

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    rd       = 1'b1;
    wr       = 1'b1;
    oe       = 1'b0;
    tx_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_rx) begin
          state_d = ST_RD_TURN;
        end else if (grant_tx) begin
          tx_ready = 1'b1;
          state_d  = ST_WR_SETUP;
        end
      end
      ST_RD_TURN: begin
        state_d  = ST_RD_STRB;
        cnt_load = 1'b1;
        cnt_val  = cyc_load(RD_CYC);
      end
      ST_RD_STRB: begin
        rd = 1'b0;
        if (cnt_zero) begin
          state_d  = ST_RECOVER;
          cnt_load = 1'b1;
          cnt_val  = cyc_load(REC_CYC);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_WR_SETUP: begin
        oe       = 1'b1;
        state_d  = ST_WR_STRB;
        cnt_load = 1'b1;
        cnt_val  = cyc_load(WR_CYC);
      end
      ST_WR_STRB: begin
        oe = 1'b1;
        wr = 1'b0;
        if (cnt_zero) begin
          state_d  = ST_RECOVER;
          cnt_load = 1'b1;
          cnt_val  = cyc_load(REC_CYC);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RECOVER: begin
        // Keep driving dq for one cycle after wr rises (write data hold).
        oe = oe_hold_q;
        if (cnt_zero) begin
          state_d = ST_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wdata_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      prefer_tx_q <= 1'b0;
      oe_hold_q   <= 1'b0;
    end else begin
      oe_hold_q <= wr_done;
      if (tx_ready) begin
        wdata_q <= tx_data;
      end
      if (rd_done) begin
        rx_data_q   <= dq;
        rx_valid_q  <= 1'b1;
        prefer_tx_q <= 1'b1;
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
      if (wr_done) begin
        prefer_tx_q <= 1'b0;
      end
    end
  end

  assign dq       = oe ? wdata_q : 'z;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_ftdi_rw_ctrl.sv
module tb_ftdi_rw_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  // Instance A: defaults (rx priority)
  logic       a_nrst, a_rxf, a_txe, a_txv, a_rxr;
  logic [7:0] a_txd, a_rxd;
  logic       a_rd, a_wr, a_oe, a_txr, a_rxv;
  wire  [7:0] a_dq;
  logic [7:0] a_chip_dir, a_chip_auto;
  bit         chip_auto = 1'b0;
  assign a_dq = a_rd ? 8'hzz : (chip_auto ? a_chip_auto : a_chip_dir);

  // Instance B: round-robin tie test, C: 16-bit bus with longer timing
  logic        bc_nrst;
  logic        b_rd, b_wr, b_oe, b_txr, b_rxv;
  logic [7:0]  b_rxd;
  wire  [7:0]  b_dq;
  assign b_dq = b_rd ? 8'hzz : 8'h77;
  logic        c_rd, c_wr, c_oe, c_txr, c_rxv;
  logic [15:0] c_rxd;
  wire  [15:0] c_dq;
  assign c_dq = c_rd ? 16'hzzzz : 16'hBEEF;

  ftdi_rw_ctrl u_a (
    .clk(clk), .n_rst(a_nrst), .rxf(a_rxf), .txe(a_txe), .rd(a_rd), .wr(a_wr),
    .oe(a_oe), .dq(a_dq), .tx_data(a_txd), .tx_valid(a_txv), .tx_ready(a_txr),
    .rx_data(a_rxd), .rx_valid(a_rxv), .rx_ready(a_rxr)
  );

  ftdi_rw_ctrl #(.ARB_RR(1)) u_b (
    .clk(clk), .n_rst(bc_nrst), .rxf(1'b0), .txe(1'b0), .rd(b_rd), .wr(b_wr),
    .oe(b_oe), .dq(b_dq), .tx_data(8'h5A), .tx_valid(1'b1), .tx_ready(b_txr),
    .rx_data(b_rxd), .rx_valid(b_rxv), .rx_ready(1'b1)
  );

  ftdi_rw_ctrl #(.DW(16), .RD_CYC(3), .REC_CYC(2)) u_c (
    .clk(clk), .n_rst(bc_nrst), .rxf(1'b0), .txe(1'b1), .rd(c_rd), .wr(c_wr),
    .oe(c_oe), .dq(c_dq), .tx_data(16'h0000), .tx_valid(1'b0), .tx_ready(c_txr),
    .rx_data(c_rxd), .rx_valid(c_rxv), .rx_ready(1'b1)
  );

  // Reference-model state
  logic [7:0]  rq[$];
  logic [7:0]  wq[$];
  logic [7:0]  b_seq[$];
  int unsigned c_falls[$];
  int unsigned a_rd_falls = 0, a_wr_falls = 0, a_rd_run = 0, a_wr_run = 0;
  logic        a_prev_rd = 1'b1, a_prev_wr = 1'b1;
  logic        b_prev_rd = 1'b1, b_prev_wr = 1'b1, c_prev_rd = 1'b1;
  int unsigned c_run = 0, c_last_run = 0;
  logic [15:0] c_last_rxd = '0;
  int unsigned base, n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon_a();
    chk("a_rd_wr_excl", !a_rd && !a_wr, 1'b0);
    chk("a_rd_oe_excl", !a_rd && a_oe, 1'b0);
    if (!a_rd) begin
      if (a_prev_rd) begin
        a_rd_falls++;
        if (chip_auto) begin
          chk("a_rd_no_overrun", a_rxv, 1'b0);
          a_chip_auto = 8'($urandom);
          rq.push_back(a_chip_auto);
        end
      end
      a_rd_run++;
    end else begin
      if (!a_prev_rd && chip_auto) chk("a_rd_len", a_rd_run, 2);
      a_rd_run = 0;
    end
    if (!a_wr) begin
      if (a_prev_wr) begin
        a_wr_falls++;
        if (chip_auto) chk("a_wr_has_word", wq.size() != 0, 1'b1);
      end
      if (chip_auto && wq.size() != 0) chk("a_wr_dq", a_dq, wq[0]);
      a_wr_run++;
    end else begin
      if (!a_prev_wr && chip_auto) begin
        chk("a_wr_len", a_wr_run, 2);
        if (wq.size() != 0) void'(wq.pop_front());
      end
      a_wr_run = 0;
    end
    a_prev_rd = a_rd;
    a_prev_wr = a_wr;
  endtask

  task automatic mon_bc();
    if (!b_rd && b_prev_rd) b_seq.push_back(8'h72);
    if (!b_wr && b_prev_wr) b_seq.push_back(8'h77);
    b_prev_rd = b_rd;
    b_prev_wr = b_wr;
    if (!c_rd) begin
      if (c_prev_rd) c_falls.push_back(cyc);
      c_run++;
    end else begin
      if (!c_prev_rd) c_last_run = c_run;
      c_run = 0;
    end
    c_prev_rd = c_rd;
    if (c_rxv) c_last_rxd = c_rxd;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    mon_a();
    mon_bc();
  endtask

  task automatic a_step(input bit rnd);
    tick();
    if (rnd) begin
      a_rxf = ($urandom_range(0, 3) == 0);
      a_txe = ($urandom_range(0, 3) == 0);
      a_txv = ($urandom_range(0, 1) == 1);
      a_txd = 8'($urandom);
      a_rxr = ($urandom_range(0, 2) != 0);
    end else begin
      a_rxf = 1'b1; a_txe = 1'b1; a_txv = 1'b0; a_rxr = 1'b1;
    end
    #1;
    chk("a_txr_only_pending", a_txr && (a_txe || !a_txv), 1'b0);
    if (a_txv && a_txr) wq.push_back(a_txd);
    if (a_rxv && a_rxr) begin
      chk("a_rx_have_word", rq.size() != 0, 1'b1);
      if (rq.size() != 0) chk("a_rx_data", a_rxd, rq.pop_front());
    end
  endtask

  initial begin
    a_nrst = 1'b0; bc_nrst = 1'b0;
    a_rxf = 1'b1; a_txe = 1'b1; a_txv = 1'b0; a_txd = '0; a_rxr = 1'b0;
    a_chip_dir = '0; a_chip_auto = '0;
    repeat (2) tick();
    chk("rst_rd", a_rd, 1'b1);
    chk("rst_wr", a_wr, 1'b1);
    chk("rst_oe", a_oe, 1'b0);
    chk("rst_rxv", a_rxv, 1'b0);
    chk("rst_rxd", a_rxd, 8'h00);
    chk("rst_txr", a_txr, 1'b0);
    a_nrst = 1'b1; bc_nrst = 1'b1;
    tick();

    // Basic read of 0xA5: grant, turnaround, 2 strobe cycles, data out
    a_rxf = 1'b0; a_rxr = 1'b1; a_chip_dir = 8'hA5;
    tick(); a_rxf = 1'b1;
    chk("rd_turn_rd", a_rd, 1'b1);
    chk("rd_turn_oe", a_oe, 1'b0);
    tick(); chk("rd_c3", a_rd, 1'b0); chk("rd_c3_oe", a_oe, 1'b0);
    tick(); chk("rd_c4", a_rd, 1'b0);
    tick(); chk("rd_c5_rd", a_rd, 1'b1); chk("rd_c5_rxv", a_rxv, 1'b1);
    chk("rd_c5_rxd", a_rxd, 8'hA5);
    tick(); chk("rd_rxv_clear", a_rxv, 1'b0);

    // Basic write of 0x3C
    a_txv = 1'b1; a_txd = 8'h3C; a_txe = 1'b0; #1;
    chk("wr_txr_pulse", a_txr, 1'b1);
    tick(); a_txv = 1'b0; a_txe = 1'b1; a_txd = 8'hFF; #1;
    chk("wr_setup_txr", a_txr, 1'b0);
    chk("wr_setup_oe", a_oe, 1'b1);
    chk("wr_setup_wr", a_wr, 1'b1);
    chk("wr_setup_dq", a_dq, 8'h3C);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("wr_strb_wr", a_wr, 1'b0);
      chk("wr_strb_oe", a_oe, 1'b1);
      chk("wr_strb_dq", a_dq, 8'h3C);
    end
    tick(); chk("wr_rec_wr", a_wr, 1'b1); chk("wr_rec_oe_hold", a_oe, 1'b1);
    tick(); chk("wr_idle_oe", a_oe, 1'b0);

    // tx_valid with txe high, then dropped: no write
    base = a_wr_falls;
    a_txv = 1'b1; a_txe = 1'b1; #1;
    chk("txe_high_txr", a_txr, 1'b0);
    repeat (3) tick();
    a_txv = 1'b0; a_txe = 1'b0;
    repeat (3) tick();
    chk("tx_drop_no_write", a_wr_falls, base);
    a_txe = 1'b1;

    // Tie with rx priority: reads only
    base = a_wr_falls; n = a_rd_falls;
    a_rxf = 1'b0; a_txe = 1'b0; a_txv = 1'b1; a_rxr = 1'b1;
    repeat (30) tick();
    chk("a_tie_no_write", a_wr_falls, base);
    chk("a_tie_reads", (a_rd_falls - n) >= 5, 1'b1);
    a_rxf = 1'b1; a_txe = 1'b1; a_txv = 1'b0;
    repeat (8) tick();

    // Backpressure: one read, then nothing while rx_valid is held
    base = a_rd_falls;
    a_rxf = 1'b0; a_rxr = 1'b1; a_chip_dir = 8'h11;
    tick(); a_rxr = 1'b0;
    repeat (4) tick();
    a_chip_dir = 8'h22;
    repeat (20) tick();
    chk("bp_one_read", a_rd_falls, base + 1);
    chk("bp_rxv_held", a_rxv, 1'b1);
    chk("bp_rxd_stable", a_rxd, 8'h11);
    a_rxr = 1'b1;
    n = 0;
    while (a_rd_falls == base + 1 && n < 12) begin
      tick();
      n++;
    end
    chk("bp_resume", a_rd_falls, base + 2);
    a_rxf = 1'b1;
    repeat (4) tick();
    chk("bp_new_data", a_rxd, 8'h22);

    // Reset during the read strobe
    a_rxf = 1'b0; a_rxr = 1'b1; a_chip_dir = 8'h99;
    tick(); a_rxf = 1'b1;
    tick(); chk("mrst_in_strb", a_rd, 1'b0);
    a_nrst = 1'b0;
    tick();
    chk("mrst_rd", a_rd, 1'b1);
    chk("mrst_oe", a_oe, 1'b0);
    chk("mrst_rxv", a_rxv, 1'b0);
    chk("mrst_rxd", a_rxd, 8'h00);
    a_nrst = 1'b1;
    tick(); chk("mrst_after_rxv", a_rxv, 1'b0);
    a_txv = 1'b1; a_txe = 1'b0; a_txd = 8'h42; #1;
    chk("mrst_idle_resumed", a_txr, 1'b1);
    tick(); a_txv = 1'b0; a_txe = 1'b1;
    repeat (5) tick();

    // Randomized traffic against the transfer-level scoreboard
    a_nrst = 1'b0;
    tick();
    a_nrst = 1'b1;
    rq.delete();
    wq.delete();
    chip_auto = 1'b1;
    repeat (1500) a_step(1'b1);
    repeat (20) a_step(1'b0);
    chk("rnd_wq_drained", wq.size(), 0);
    chk("rnd_rq_drained", rq.size(), 0);
    chip_auto = 1'b0;

    // Round-robin grants on B: rx, tx, rx, tx ...
    chk("b_tie_count", b_seq.size() >= 6, 1'b1);
    for (int i = 0; i < 6; i++) begin
      if (i < b_seq.size()) chk("b_tie_alt", b_seq[i], (i % 2 == 0) ? 8'h72 : 8'h77);
    end

    // 16-bit bus, RD_CYC=3, REC_CYC=2
    chk("c_fall_count", c_falls.size() >= 2, 1'b1);
    if (c_falls.size() >= 2) chk("c_period", c_falls[1] - c_falls[0], 7);
    chk("c_rd_len", c_last_run, 3);
    chk("c_rx_word", c_last_rxd, 16'hBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
